// File: rtl/sysid_check_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// sysid_ctrl_pkg
// Shared types and constants for the system-ID check sequencer:
//   state_t              sequencer FSM states
//   ADDR_ID / ADDR_TS    sysid word selects (0 = ID, 1 = build timestamp)
//   READ_LATENCY_MAX     largest slave read latency the read port supports
//   stall_cnt_width()    width of the waitrequest stall counter, which is only
//                        built when SYSID_TIMEOUT_EN is defined
// -----------------------------------------------------------------------------
package sysid_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_ID  = 3'd1,
    ST_LAT_ID = 3'd2,
    ST_RD_TS  = 3'd3,
    ST_LAT_TS = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam int READ_LATENCY_MAX = 3;

  // Stall counter width: enough bits to hold the timeout count, kept in 8..16.
  function automatic int stall_cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 8) w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/sysid_check_sequencer_if.sv
// -----------------------------------------------------------------------------
// sysid_check_sequencer_if
// Avalon-MM read-only bus between the check sequencer (master) and the
// system-ID slave.
//   m_address      master -> slave  word select (0 = ID, 1 = timestamp)
//   m_read         master -> slave  read strobe
//   m_waitrequest  slave -> master  stall; read is accepted when low
//   m_readdata     slave -> master  32-bit read data
// -----------------------------------------------------------------------------
interface sysid_check_sequencer_if;
  logic        m_address;
  logic        m_read;
  logic        m_waitrequest;
  logic [31:0] m_readdata;

  modport master (
    output m_address,
    output m_read,
    input  m_waitrequest,
    input  m_readdata
  );

  modport slave (
    input  m_address,
    input  m_read,
    output m_waitrequest,
    output m_readdata
  );
endinterface

// File: rtl/sysid_check_sequencer_read_port.sv
// -----------------------------------------------------------------------------
// sysid_read_port
// Single-read Avalon-MM handshake used by the check sequencer.
// Optional feature macro: SYSID_TIMEOUT_EN (waitrequest stall timeout).
//   clock, reset_n  system clock, asynchronous active-low reset
//   i_req           hold high while the read is outstanding (drives m_read)
//   i_addr          word select, passed straight to m_address
//   bus             Avalon master side of the sysid bus
//   o_data          m_readdata, meaningful when o_valid is high
//   o_accept        read accepted this cycle (i_req and no waitrequest)
//   o_valid         read data valid this cycle: the accept cycle when
//                   READ_LATENCY = 0, else READ_LATENCY cycles later
//   o_timeout       stall limit reached this cycle (always 0 without macro)
// -----------------------------------------------------------------------------
module sysid_read_port
  import sysid_ctrl_pkg::*;
#(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           i_req,
  input  logic                           i_addr,
  sysid_check_sequencer_if.master        bus,
  output logic [31:0]                    o_data,
  output logic                           o_accept,
  output logic                           o_valid,
  output logic                           o_timeout
);

  // Out-of-range latencies are clamped to what the 2-bit countdown can hold.
  localparam int LAT = (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX :
                       (READ_LATENCY < 0)                ? 0 : READ_LATENCY;

  logic [1:0] r_lat_cnt;

  assign bus.m_read    = i_req;
  assign bus.m_address = i_addr;
  assign o_accept      = i_req & ~bus.m_waitrequest;
  assign o_data        = bus.m_readdata;

  // Countdown loaded on acceptance; data is valid on the cycle it reads 1,
  // which is exactly LAT cycles after the accept cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lat_cnt <= 2'd0;
    end else if (o_accept) begin
      r_lat_cnt <= 2'(LAT);
    end else if (r_lat_cnt != 2'd0) begin
      r_lat_cnt <= r_lat_cnt - 2'd1;
    end
  end

  assign o_valid = (LAT == 0) ? o_accept : (r_lat_cnt == 2'd1);

`ifdef SYSID_TIMEOUT_EN
  localparam int STALL_W = stall_cnt_width(TIMEOUT_CYCLES);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

  logic [STALL_W-1:0] r_stall_cnt;
  logic               w_stalling;

  assign w_stalling = i_req & bus.m_waitrequest;
  // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle; the sequencer
  // leaves the read state on the next edge, which drops m_read.
  assign o_timeout  = w_stalling & (r_stall_cnt == STALL_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (!w_stalling || o_timeout) begin
      r_stall_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: rtl/sysid_check_sequencer.sv
// -----------------------------------------------------------------------------
// sysid_check_sequencer
// Boot-time / on-demand verifier for the system-ID slave. Reads word 0 (ID)
// and word 1 (build timestamp), latches them and compares each against the
// value baked in at generation.
// Optional feature macro: SYSID_TIMEOUT_EN (abort a read stalled for
// TIMEOUT_CYCLES cycles and flag timeout_err).
//   clock            system clock, rising edge
//   reset_n          asynchronous active-low reset
//   start            one-cycle pulse to begin a check (ignored while busy)
//   m_bus            Avalon-MM read master to the sysid slave
//   id_value         last captured word 0
//   timestamp_value  last captured word 1
//   busy             check in progress
//   done             one-cycle pulse when a check ends
//   id_match         id_value == EXPECTED_ID, valid from done onward
//   ts_match         timestamp_value == EXPECTED_TIMESTAMP, valid from done
//   timeout_err      sticky stall-timeout flag, cleared by the next start
// -----------------------------------------------------------------------------
module sysid_check_sequencer
  import sysid_ctrl_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1620606931,
  parameter int          READ_LATENCY       = 0,
  parameter int          AUTO_START         = 1,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  sysid_check_sequencer_if.master m_bus,
  output logic [31:0]             id_value,
  output logic [31:0]             timestamp_value,
  output logic                    busy,
  output logic                    done,
  output logic                    id_match,
  output logic                    ts_match,
  output logic                    timeout_err
);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_auto_pending;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;
  logic        r_id_match;
  logic        r_ts_match;

  logic        w_req;
  logic        w_addr;
  logic [31:0] w_data;
  logic        w_accept;
  logic        w_valid;
  logic        w_timeout;
  logic        w_launch;
  logic        w_cap_id;
  logic        w_cap_ts;

  // Bus controls depend on state only, so the read port's accept/valid can
  // feed the next-state logic without a combinational loop.
  assign w_req  = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
  assign w_addr = ((r_state == ST_RD_TS) || (r_state == ST_LAT_TS)) ? ADDR_TS : ADDR_ID;

  sysid_read_port #(
    .READ_LATENCY   (READ_LATENCY),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_read_port (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_req     (w_req),
    .i_addr    (w_addr),
    .bus       (m_bus),
    .o_data    (w_data),
    .o_accept  (w_accept),
    .o_valid   (w_valid),
    .o_timeout (w_timeout)
  );

  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    w_cap_id     = 1'b0;
    w_cap_ts     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start || r_auto_pending) begin
          w_launch     = 1'b1;
          w_state_next = ST_RD_ID;
        end
      end
      ST_RD_ID: begin
        // With zero latency valid and accept coincide, skipping LAT_ID.
        if (w_timeout) begin
          w_state_next = ST_FINISH;
        end else if (w_valid) begin
          w_cap_id     = 1'b1;
          w_state_next = ST_RD_TS;
        end else if (w_accept) begin
          w_state_next = ST_LAT_ID;
        end
      end
      ST_LAT_ID: begin
        if (w_valid) begin
          w_cap_id     = 1'b1;
          w_state_next = ST_RD_TS;
        end
      end
      ST_RD_TS: begin
        if (w_timeout) begin
          w_state_next = ST_FINISH;
        end else if (w_valid) begin
          w_cap_ts     = 1'b1;
          w_state_next = ST_FINISH;
        end else if (w_accept) begin
          w_state_next = ST_LAT_TS;
        end
      end
      ST_LAT_TS: begin
        if (w_valid) begin
          w_cap_ts     = 1'b1;
          w_state_next = ST_FINISH;
        end
      end
      ST_FINISH: begin
        // start seen here is dropped on purpose: we always pass through IDLE.
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_auto_pending <= (AUTO_START != 0);
      r_id_value     <= 32'd0;
      r_ts_value     <= 32'd0;
      r_id_match     <= 1'b0;
      r_ts_match     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_launch) begin
        r_auto_pending <= 1'b0;
        r_id_match     <= 1'b0;
        r_ts_match     <= 1'b0;
      end
      if (w_cap_id) begin
        r_id_value <= w_data;
      end
      // Both flags are registered on the edge into FINISH so they are
      // already valid while done is high.
      if (w_cap_ts) begin
        r_ts_value <= w_data;
        r_id_match <= (r_id_value == EXPECTED_ID);
        r_ts_match <= (w_data == EXPECTED_TIMESTAMP);
      end
      if (w_timeout) begin
        r_id_match <= 1'b0;
        r_ts_match <= 1'b0;
      end
    end
  end

`ifdef SYSID_TIMEOUT_EN
  logic r_timeout_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout_err <= 1'b0;
    end else if (w_launch) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  assign id_value        = r_id_value;
  assign timestamp_value = r_ts_value;
  assign busy            = (r_state != ST_IDLE) && (r_state != ST_FINISH);
  assign done            = (r_state == ST_FINISH);
  assign id_match        = r_id_match;
  assign ts_match        = r_ts_match;

endmodule

// File: tb/tb_sysid_check_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sysid_check_sequencer
// Directed bench for sysid_check_sequencer. Two instances share one clock:
//   A: READ_LATENCY = 0, zero-wait slave, EXPECTED_ID = 0
//   B: READ_LATENCY = 2, stallable slave, EXPECTED_ID = 32'hA5A5_0001,
//      TIMEOUT_CYCLES = 4 (used when SYSID_TIMEOUT_EN is defined)
// Cycle numbers: period 0 is the clock period in which start is high (or in
// which reset is released); the DUT samples it on the edge ending period 0.
// -----------------------------------------------------------------------------
module tb_sysid_check_sequencer;

  localparam logic [31:0] TS_OK = 32'd1620606931;
  localparam logic [31:0] ID_A  = 32'h0000_0000;
  localparam logic [31:0] ID_B  = 32'hA5A5_0001;
  localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_a_n, rst_b_n, start_a, start_b, wait_a, wait_b;
  logic [31:0] id_a_rd, ts_a_rd, id_b_rd, ts_b_rd;

  logic [31:0] id_value_a, ts_value_a, id_value_b, ts_value_b;
  logic        busy_a, done_a, id_match_a, ts_match_a, timeout_err_a;
  logic        busy_b, done_b, id_match_b, ts_match_b, timeout_err_b;

  int n_tests = 0;
  int n_fail  = 0;

  sysid_check_sequencer_if bus_a ();
  sysid_check_sequencer_if bus_b ();

  // Slave A: zero wait state, zero latency; junk whenever not being read.
  assign bus_a.m_waitrequest = wait_a;
  assign bus_a.m_readdata    = (bus_a.m_read && !wait_a) ?
                               (bus_a.m_address ? ts_a_rd : id_a_rd) : JUNK;

  // Slave B: fixed latency 2, data only on the cycle it is due.
  logic [1:0] b_vld = 2'b00;
  logic [1:0] b_adr = 2'b00;
  always @(posedge clock) begin
    b_vld <= {b_vld[0], bus_b.m_read & ~wait_b};
    b_adr <= {b_adr[0], bus_b.m_address};
  end
  assign bus_b.m_waitrequest = wait_b;
  assign bus_b.m_readdata    = b_vld[1] ? (b_adr[1] ? ts_b_rd : id_b_rd) : JUNK;

  sysid_check_sequencer #(
    .EXPECTED_ID        (ID_A),
    .EXPECTED_TIMESTAMP (TS_OK),
    .READ_LATENCY       (0),
    .AUTO_START         (1),
    .TIMEOUT_CYCLES     (255)
  ) u_dut_a (
    .clock           (clock),
    .reset_n         (rst_a_n),
    .start           (start_a),
    .m_bus           (bus_a),
    .id_value        (id_value_a),
    .timestamp_value (ts_value_a),
    .busy            (busy_a),
    .done            (done_a),
    .id_match        (id_match_a),
    .ts_match        (ts_match_a),
    .timeout_err     (timeout_err_a)
  );

  sysid_check_sequencer #(
    .EXPECTED_ID        (ID_B),
    .EXPECTED_TIMESTAMP (TS_OK),
    .READ_LATENCY       (2),
    .AUTO_START         (1),
    .TIMEOUT_CYCLES     (4)
  ) u_dut_b (
    .clock           (clock),
    .reset_n         (rst_b_n),
    .start           (start_b),
    .m_bus           (bus_b),
    .id_value        (id_value_b),
    .timestamp_value (ts_value_b),
    .busy            (busy_b),
    .done            (done_b),
    .id_match        (id_match_b),
    .ts_match        (ts_match_b),
    .timeout_err     (timeout_err_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] pass %s: 0x%08h", tag, got);
    end
  endtask

  // Called #1 after a posedge (start of period 0). Returns the period in
  // which done is first seen, or -1 if it never appears within the budget.
  task automatic run_check(input bit which, input bit pulse, output int cyc);
    cyc = -1;
    if (pulse) begin
      if (which) start_b = 1'b1;
      else       start_a = 1'b1;
    end
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      if ((which ? done_b : done_a) === 1'b1) begin
        cyc = k;
        break;
      end
      @(posedge clock);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  int cyc;
  int first;
  int n_done;

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    wait_a  = 1'b0; wait_b  = 1'b0;
    id_a_rd = ID_A; ts_a_rd = TS_OK;
    id_b_rd = ID_B; ts_b_rd = TS_OK;

    // Reset state: every output low.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_val("rst_flags_a", {26'd0, busy_a, done_a, id_match_a, ts_match_a,
                              timeout_err_a, bus_a.m_read}, 32'd0);
    check_val("rst_id_value_a", id_value_a, 32'd0);
    check_val("rst_ts_value_a", ts_value_a, 32'd0);
    check_val("rst_flags_b", {25'd0, busy_b, done_b, id_match_b, ts_match_b,
                              timeout_err_b, bus_b.m_read, bus_b.m_address}, 32'd0);

    // 1: auto-start after reset release, zero-wait slave -> done in period 3.
    @(posedge clock); #1;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    run_check(1'b0, 1'b0, cyc);
    check_val("t1_done_cycle", cyc, 32'd3);
    check_val("t1_matches", {30'd0, id_match_a, ts_match_a}, 32'd3);
    check_val("t1_id_value", id_value_a, ID_A);
    check_val("t1_ts_value", ts_value_a, TS_OK);
    repeat (10) @(posedge clock);
    #1;
    check_val("t1_b_matches", {30'd0, id_match_b, ts_match_b}, 32'd3);
    check_val("t1_b_id_value", id_value_b, ID_B);

    // 2: timestamp off by one -> ts_match 0, id_match 1.
    ts_a_rd = TS_OK - 32'd1;
    @(posedge clock); #1;
    run_check(1'b0, 1'b1, cyc);
    check_val("t2_done_cycle", cyc, 32'd3);
    check_val("t2_matches", {30'd0, id_match_a, ts_match_a}, 32'd2);
    check_val("t2_ts_value", ts_value_a, 32'd1620606930);
    repeat (4) @(negedge clock);
    check_val("t2_hold", {30'd0, id_match_a, ts_match_a}, 32'd2);

    // 4: start held through periods 0..3 (busy and FINISH) -> one done only.
    ts_a_rd = TS_OK;
    @(posedge clock); #1;
    start_a = 1'b1;
    n_done  = 0;
    first   = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      if (done_a === 1'b1) begin
        n_done++;
        if (first < 0) first = k;
      end
      @(posedge clock); #1;
      start_a = (k < 3);
    end
    check_val("t4_done_count", n_done, 32'd1);
    check_val("t4_done_cycle", first, 32'd3);
    check_val("t4_matches", {30'd0, id_match_a, ts_match_a}, 32'd3);

    // 3: latency 2, waitrequest high in periods 3..7. RD_ID 1, LAT_ID 2-3,
    // RD_TS stalled 4-7 and accepted 8, LAT_TS 9-10, FINISH 11.
    @(posedge clock); #1;
    start_b = 1'b1;
    first   = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (k >= 4 && k <= 7)
        check_val($sformatf("t3_stall_p%0d", k), {30'd0, bus_b.m_read, bus_b.m_address}, 32'd3);
      if (k == 9)
        check_val("t3_lat_ts_p9", {30'd0, bus_b.m_read, bus_b.m_address}, 32'd1);
      if (done_b === 1'b1 && first < 0) first = k;
      @(posedge clock); #1;
      start_b = 1'b0;
      wait_b  = (k + 1 >= 3) && (k + 1 <= 7);
    end
    check_val("t3_done_cycle", first, 32'd11);
    check_val("t3_id_value", id_value_b, ID_B);
    check_val("t3_ts_value", ts_value_b, TS_OK);
    check_val("t3_matches", {30'd0, id_match_b, ts_match_b}, 32'd3);

    // 5: reset in LAT_TS (period 5 with latency 2), then auto-rerun.
    @(posedge clock); #1;
    start_b = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clock);
      if (k == 5) break;
      @(posedge clock); #1;
      start_b = 1'b0;
    end
    check_val("t5_busy_before", {31'd0, busy_b}, 32'd1);
    rst_b_n = 1'b0;
    #1;
    check_val("t5_rst_flags", {25'd0, busy_b, done_b, id_match_b, ts_match_b,
                               timeout_err_b, bus_b.m_read, bus_b.m_address}, 32'd0);
    check_val("t5_rst_id_value", id_value_b, 32'd0);
    check_val("t5_rst_ts_value", ts_value_b, 32'd0);
    @(posedge clock); #1;
    rst_b_n = 1'b1;
    run_check(1'b1, 1'b0, cyc);
    check_val("t5_rerun_cycle", cyc, 32'd7);
    check_val("t5_rerun_matches", {30'd0, id_match_b, ts_match_b}, 32'd3);
    check_val("t5_rerun_id_value", id_value_b, ID_B);

`ifdef SYSID_TIMEOUT_EN
    // 6: waitrequest stuck; RD_ID stalls periods 1..4, timeout, FINISH in 5.
    @(posedge clock); #1;
    wait_b  = 1'b1;
    start_b = 1'b1;
    first   = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (k >= 1 && k <= 4)
        check_val($sformatf("t6_mread_p%0d", k), {31'd0, bus_b.m_read}, 32'd1);
      if (k == 5)
        check_val("t6_mread_p5", {31'd0, bus_b.m_read}, 32'd0);
      if (done_b === 1'b1 && first < 0) first = k;
      @(posedge clock); #1;
      start_b = 1'b0;
    end
    check_val("t6_done_cycle", first, 32'd5);
    check_val("t6_timeout_err", {31'd0, timeout_err_b}, 32'd1);
    check_val("t6_matches", {30'd0, id_match_b, ts_match_b}, 32'd0);
    wait_b = 1'b0;
    @(posedge clock); #1;
    run_check(1'b1, 1'b1, cyc);
    check_val("t6_recover_cycle", cyc, 32'd7);
    check_val("t6_recover_flags", {29'd0, timeout_err_b, id_match_b, ts_match_b}, 32'd3);
`else
    // 6 (timeout disabled): a stuck slave just stalls, no done, no error.
    @(posedge clock); #1;
    wait_b  = 1'b1;
    start_b = 1'b1;
    n_done  = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done_b === 1'b1) n_done++;
      @(posedge clock); #1;
      start_b = 1'b0;
    end
    check_val("t6_no_done", n_done, 32'd0);
    check_val("t6_still_reading", {29'd0, busy_b, bus_b.m_read, timeout_err_b}, 32'd6);
    // Released in period 0: accept 0, LAT_ID 1-2, RD_TS 3, LAT_TS 4-5, FINISH 6.
    wait_b = 1'b0;
    run_check(1'b1, 1'b0, cyc);
    check_val("t6_release_cycle", cyc, 32'd6);
    check_val("t6_release_matches", {30'd0, id_match_b, ts_match_b}, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
